rd_code_pack: RTL and testbench
===============================

# rd_code_pack

Serial-to-parallel packer that sits directly downstream of the radial-difference comparison stage in the NIRD pipeline. It consumes one comparison bit per `done_i` strobe, assembles `NUM_BITS` consecutive bits into one descriptor code per pixel, and presents the code with a single-cycle `done_o` strobe to the histogram/feature stage. An optional compile-time mapping replaces each code with its rotation-invariant minimum.

## Interface
Parameters:
- `NUM_BITS`, default 8: bits per code (sampling directions per pixel); legal range 2..16.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `bit_i`  in  1  comparison bit from the upstream stage; sampled only when `done_i`=1.
- `done_i`  in  1  bit-valid strobe, aligned with `bit_i`.
- `sync_i`  in  1  pixel-boundary resync; clears any partial code.
- `code_o`  out  NUM_BITS  packed (optionally mapped) code; held between strobes.
- `done_o`  out  1  one-cycle strobe: `code_o` valid this cycle.
- `drop_o`  out  1  one-cycle pulse: a partial code was discarded by `sync_i`.

## Operation
- Registers: shift register `sr[NUM_BITS-1:0]`, bit counter `cnt` (width clog2(NUM_BITS)), output register `code_o`.
- States: IDLE (cnt=0), FILL (0<cnt<NUM_BITS-1), LAST (cnt=NUM_BITS-1). Implicit in `cnt`; no separate state register.
- On `done_i`: `sr[cnt] <= bit_i` (first received bit -> LSB, last -> MSB); `cnt` increments.
- On `done_i` in LAST: full code = {bit_i, sr[NUM_BITS-2:0]} is loaded into the output path; `cnt` wraps to 0; next `done_i` starts a new code with no gap cycle.
- `done_i` may be asserted every cycle; sustained throughput is one code per NUM_BITS cycles.
- `sync_i`=1: `cnt` forced to 0 before the same-cycle `done_i` is applied, i.e. a coincident `bit_i` becomes bit 0 of the new code. If `cnt`≠0 at that edge, `drop_o` pulses next cycle; if `cnt`=0, no pulse.
- `sync_i` coincident with a LAST `done_i`: sync wins; no code emitted, `drop_o` pulses, bit taken as bit 0.
- `done_i`=0: no state change; `code_o` holds.
- `rst` mid-code: partial code discarded silently (no `drop_o`), pipeline stage (if present) flushed, no `done_o` for the in-flight code.

## Timing
- Reset values: `code_o`=0, `done_o`=0, `drop_o`=0, `cnt`=0, `sr`=0.
- Latency without mapping: `done_o` asserts 1 cycle after the edge sampling the NUM_BITS-th `done_i`.
- Latency with mapping: 2 cycles (raw code registered, then mapped code registered to `code_o`).
- `done_o` never asserts on two consecutive cycles for NUM_BITS≥2.
- `drop_o` asserts exactly 1 cycle after the offending `sync_i` edge.

## Configuration
- Macro `RD_ROT_INV_EN`.
- Defined: output stage computes the minimum unsigned value over all NUM_BITS circular rotations of the raw code (comparator tree, one register stage); `code_o` carries that minimum; latency 2.
- Undefined: raw code passes straight to `code_o`; latency 1; rotation logic absent.

## Test plan
- Reset: hold `rst` 3 cycles mid-stream -> all outputs 0, next 8 bits form a fresh code, no `drop_o`.
- NUM_BITS=8, bits 1,0,1,1,0,0,0,1 on 8 consecutive `done_i` -> `code_o`=0x8D, `done_o` one cycle (macro off); with `RD_ROT_INV_EN` -> `code_o`=0x1B, two cycles after last bit.
- Back-to-back: 24 continuous `done_i` with bit pattern all-1 then all-0 then 0x55 LSB-first -> three `done_o` strobes spaced 8 cycles, codes 0xFF, 0x00, 0x55 (0x55 with macro).
- Gapped input: 8 bits with random idle cycles between strobes -> same code as gapless, `code_o` held unchanged during gaps.
- Resync: 5 bits, then `sync_i` with `done_i`=1, bit=1, then 7 bits of 0 -> `drop_o` pulse once, emitted code=0x01 (macro off).
- `sync_i` with `cnt`=0 and coincident with 8th bit -> no pulse in first case, `drop_o` pulse and no `done_o` in second.

Source files
------------

// File: rtl/rd_code_pack.sv
// Serial-to-parallel packer: NUM_BITS comparison bits (LSB first) -> one descriptor code.
// Define RD_ROT_INV_EN to replace each code with its minimum circular rotation (adds one cycle).
module rd_code_pack #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_i,
  input  logic                done_i,
  input  logic                sync_i,
  output logic [NUM_BITS-1:0] code_o,
  output logic                done_o,
  output logic                drop_o
);

  localparam int CNT_W = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_eff;
  logic [NUM_BITS-1:0] raw_d;
  logic                vld_d;
  logic                drop_d;
  logic [NUM_BITS-1:0] code_q, code_d;
  logic                done_q, done_d;
  logic                drop_q;

  // Stage 0: bit assembly; sync clears the count before the same-cycle bit lands
  always_comb begin
    cnt_eff = sync_i ? '0 : cnt_q;
    sr_d    = sr_q;
    cnt_d   = cnt_eff;
    raw_d   = {bit_i, sr_q[NUM_BITS-2:0]};
    vld_d   = 1'b0;
    drop_d  = sync_i && (cnt_q != '0);
    if (done_i) begin
      sr_d[cnt_eff] = bit_i;
      if (cnt_eff == CNT_LAST) begin
        cnt_d = '0;
        vld_d = 1'b1;
      end else begin
        cnt_d = cnt_eff + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef RD_ROT_INV_EN
  function automatic logic [NUM_BITS-1:0] rot_min(input logic [NUM_BITS-1:0] c);
    logic [NUM_BITS-1:0] best;
    logic [NUM_BITS-1:0] rot;
    best = c;
    for (int r = 1; r < NUM_BITS; r++) begin
      rot = (c >> r) | (c << (NUM_BITS - r));
      if (rot < best) best = rot;
    end
    return best;
  endfunction

  logic [NUM_BITS-1:0] raw_p0_q;
  logic                vld_p0_q;

  // Stage 1: raw code registered ahead of the rotation comparator tree
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_p0_q <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_d;
      if (vld_d) raw_p0_q <= raw_d;
    end
  end

  assign code_d = rot_min(raw_p0_q);
  assign done_d = vld_p0_q;
`else
  assign code_d = raw_d;
  assign done_d = vld_d;
`endif

  // Output stage: code held between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (done_d) code_q <= code_d;
      done_q <= done_d;
      drop_q <= drop_d;
    end
  end

  assign code_o = code_q;
  assign done_o = done_q;
  assign drop_o = drop_q;

endmodule

// File: tb/tb_rd_code_pack.sv
// Directed bench for rd_code_pack (NUM_BITS=8) with a bit-queue reference model.
module tb_rd_code_pack;
  localparam int NB = 8;
`ifdef RD_ROT_INV_EN
  localparam int LAT = 2;
  localparam logic [NB-1:0] E_A = 8'h1B;
  localparam logic [NB-1:0] E_R = 8'h2D;
`else
  localparam int LAT = 1;
  localparam logic [NB-1:0] E_A = 8'h8D;
  localparam logic [NB-1:0] E_R = 8'h96;
`endif

  logic clk = 1'b0;
  logic rst, bit_i, done_i, sync_i;
  logic [NB-1:0] code_o;
  logic done_o, drop_o;

  rd_code_pack #(.NUM_BITS(NB)) dut (
    .clk(clk), .rst(rst), .bit_i(bit_i), .done_i(done_i), .sync_i(sync_i),
    .code_o(code_o), .done_o(done_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: collect bits in a queue, form the code arithmetically
  function automatic logic [NB-1:0] model_code(input logic [NB-1:0] raw);
    int best, val;
    best = int'(raw);
`ifdef RD_ROT_INV_EN
    for (int r = 0; r < NB; r++) begin
      val = 0;
      for (int i = 0; i < NB; i++) val += int'(raw[(i + r) % NB]) << i;
      if (val < best) best = val;
    end
`endif
    return best[NB-1:0];
  endfunction

  int bq[$];
  int pv[$];
  logic [NB-1:0] pc[$];
  int edge_n = 0;
  bit started = 0;
  logic m_done = 0, m_drop = 0;
  logic [NB-1:0] m_code = '0;

  always @(posedge clk) begin
    logic [NB-1:0] raw;
    started = 1;
    edge_n++;
    if (rst) begin
      bq.delete(); pv.delete(); pc.delete();
      m_done = 0; m_drop = 0; m_code = '0;
    end else begin
      m_drop = sync_i && (bq.size() != 0);
      if (sync_i) bq.delete();
      if (done_i) begin
        bq.push_back(int'(bit_i));
        if (bq.size() == NB) begin
          raw = '0;
          foreach (bq[i]) raw = raw | (NB'(bq[i]) << i);
          pv.push_back(edge_n + LAT - 1);
          pc.push_back(model_code(raw));
          bq.delete();
        end
      end
      m_done = 0;
      if (pv.size() > 0 && pv[0] == edge_n) begin
        m_done = 1;
        m_code = pc[0];
        void'(pv.pop_front());
        void'(pc.pop_front());
      end
    end
  end

  // Per-cycle comparison plus capture of emitted codes and drop pulses
  logic [NB-1:0] seen[$];
  int drops = 0;
  always @(negedge clk) begin
    if (started) begin
      check("done_o", int'(done_o), int'(m_done));
      check("drop_o", int'(drop_o), int'(m_drop));
      check("code_o", int'(code_o), int'(m_code));
      if (done_o) seen.push_back(code_o);
      if (drop_o) drops++;
    end
  end

  task automatic step(input logic d, input logic b, input logic s);
    done_i = d; bit_i = b; sync_i = s;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [NB-1:0] v, input int max_gap);
    for (int i = 0; i < NB; i++) begin
      step(1'b1, v[i], 1'b0);
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        for (int k = 0; k < g; k++) step(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_seen(input string nm, input logic [NB-1:0] exp);
    if (seen.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no code captured, expected 0x%0h", nm, exp);
    end else begin
      check(nm, int'(seen[0]), int'(exp));
      void'(seen.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; bit_i = 1'b0; done_i = 1'b0; sync_i = 1'b0;
    idle(3);
    rst = 1'b0;
    check("reset_code", int'(code_o), 0);
    check("reset_done", int'(done_o), 0);
    check("reset_drop", int'(drop_o), 0);

    // 1,0,1,1,0,0,0,1 LSB first
    send_byte(8'h8D, 0);
    idle(3);

    // back-to-back: all ones, all zeros, 0x55
    send_byte(8'hFF, 0);
    send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    idle(3);

    send_byte(8'h8D, 3);
    idle(3);

    // resync: 5 bits, sync with bit=1, then 7 zeros
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("resync_drop", int'(drop_o), 1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    idle(3);

    // sync at cnt=0: no drop
    step(1'b0, 1'b0, 1'b1);
    check("sync_idle_drop", int'(drop_o), 0);
    // sync coincident with 8th bit: drop, no code, bit becomes bit 0
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("sync_last_drop", int'(drop_o), 1);
    check("sync_last_done", int'(done_o), 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    idle(3);

    // reset mid-code: 4 bits, rst held 3 cycles, then a fresh code
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("midrst_code", int'(code_o), 0);
    check("midrst_done", int'(done_o), 0);
    check("midrst_drop", int'(drop_o), 0);
    send_byte(8'h96, 0);
    idle(4);

    check("code_count", seen.size(), 8);
    expect_seen("code_8d", E_A);
    expect_seen("code_ff", 8'hFF);
    expect_seen("code_00", 8'h00);
    expect_seen("code_55", 8'h55);
    expect_seen("code_gapped", E_A);
    expect_seen("code_resync", 8'h01);
    expect_seen("code_sync_last", 8'h01);
    expect_seen("code_after_rst", E_R);
    check("drop_count", drops, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
